lcd_bus_responder: RTL and testbench

- HD44780-compatible responder: the receiving end of the 8-bit parallel LCD bus (data, RS, RW, EN) that our LCD controller drives.
- Decodes instruction and data writes, maintains an 80-byte DDRAM image, cursor and display state, and answers busy-flag and data reads.
- Serves as an on-chip display mirror (peek port) and as a synthesizable bus model for the controller's bench.

---
 rtl/lcd_bus_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible bus responder: decodes writes/reads on the 8-bit LCD bus, keeps an 80-byte DDRAM mirror.
// Optional display-shift offset state is enabled by defining LCD_RESP_DISPLAY_SHIFT_EN.
module lcd_bus_responder #(
    parameter int CMD_CYCLES   = 40,
    parameter int CLEAR_CYCLES = 40
) (
    input  logic       i_clk,
    input  logic       reset_internal,
    input  logic [7:0] i_lcd_data,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_en,
    output logic [7:0] o_lcd_rdata,
    output logic       o_lcd_rdata_oe,
    output logic       o_busy,
    output logic [6:0] o_cursor,
    output logic       o_disp_on,
    output logic       o_cur_on,
    output logic       o_blink_on,
    output logic       o_dl8,
    output logic       o_two_line,
    input  logic [6:0] i_peek_idx,
    output logic [7:0] o_peek_char,
    output logic       o_err
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
    ,
    output logic [6:0] o_disp_offset
`endif
);

    localparam int CW         = 16;
    localparam int CLR_EFF    = (CLEAR_CYCLES > 40) ? CLEAR_CYCLES : 40;
    localparam int FILL_EXTRA = CLR_EFF - 40;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FILL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    fill_k, k_n;

    logic       en_q, rs_q, rw_q;
    logic [7:0] data_q;
    logic [6:0] ac;
    logic       id_inc;
    logic [7:0] mem [80];
    logic       fall, wr_ev, rd_ev, idle, wr_data;
    logic [6:0] midx;
    logic [7:0] mem_rd, rd_val;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic two);
        if (two) begin
            if (inc) return (a == 7'h27) ? 7'h40 : (a >= 7'h67) ? 7'h00 : a + 7'd1;
            else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end else begin
            if (inc) return (a >= 7'h4F) ? 7'h00 : a + 7'd1;
            else     return (a == 7'h00) ? 7'h4F : a - 7'd1;
        end
    endfunction

    // Second line (0x40..0x67) lives in the upper 40-byte bank
    function automatic logic [6:0] map_idx(input logic [6:0] a, input logic two);
        return (two && a >= 7'h40) ? a - 7'd24 : a;
    endfunction

    function automatic logic ac_illegal(input logic [6:0] a, input logic two);
        if (two) return (a >= 7'h28 && a <= 7'h3F) || (a >= 7'h68);
        else     return a >= 7'h50;
    endfunction

    assign idle    = (state == S_IDLE);
    assign fall    = en_q & ~i_lcd_en;
    assign wr_ev   = fall & ~rw_q;
    assign rd_ev   = fall & rw_q & rs_q;
    assign wr_data = wr_ev & rs_q & idle;
    assign midx    = map_idx(ac, o_two_line);
    assign mem_rd  = (midx < 7'd80) ? mem[midx] : 8'h00;
    assign o_busy  = ~idle;
    assign o_cursor = ac;

    always_comb begin
        rd_val = {o_busy, ac};
        if (i_lcd_rs) rd_val = idle ? mem_rd : 8'h00;
    end

    always_ff @(posedge i_clk or posedge reset_internal) begin
        if (reset_internal) begin
            state  <= S_FILL;
            cnt    <= '0;
            fill_k <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            fill_k <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = fill_k;
        unique case (state)
            S_FILL: begin
                if (fill_k == 6'd39) begin
                    k_n = '0;
                    if (FILL_EXTRA == 0) state_n = S_IDLE;
                    else begin
                        state_n = S_BUSY;
                        cnt_n   = CW'(FILL_EXTRA - 1);
                    end
                end else begin
                    k_n = fill_k + 6'd1;
                end
            end
            S_BUSY: begin
                if (cnt == '0) state_n = S_IDLE;
                else           cnt_n = cnt - 1'b1;
            end
            default: begin
                if (wr_ev && !rs_q && data_q == 8'h01) begin
                    state_n = S_FILL;
                    k_n     = '0;
                end else if (wr_ev && !rs_q && data_q[7:1] == 7'h01) begin
                    state_n = S_BUSY;
                    cnt_n   = CW'(CLR_EFF - 1);
                end else if ((wr_ev || rd_ev) && CMD_CYCLES > 0) begin
                    state_n = S_BUSY;
                    cnt_n   = CW'(CMD_CYCLES - 1);
                end
            end
        endcase
    end

`ifdef LCD_RESP_DISPLAY_SHIFT_EN
    logic [6:0] disp_off;
    logic       shift_s;
    assign o_disp_offset = disp_off;

    function automatic logic [6:0] off_step(input logic [6:0] o, input logic inc, input logic two);
        logic [6:0] last;
        last = two ? 7'd39 : 7'd79;
        if (inc) return (o >= last) ? 7'd0 : o + 7'd1;
        else     return (o == 7'd0) ? last : o - 7'd1;
    endfunction
`endif

    always_ff @(posedge i_clk or posedge reset_internal) begin
        if (reset_internal) begin
            en_q           <= 1'b0;
            rs_q           <= 1'b0;
            rw_q           <= 1'b0;
            data_q         <= 8'h00;
            ac             <= 7'h00;
            id_inc         <= 1'b1;
            o_disp_on      <= 1'b0;
            o_cur_on       <= 1'b0;
            o_blink_on     <= 1'b0;
            o_dl8          <= 1'b1;
            o_two_line     <= 1'b0;
            o_err          <= 1'b0;
            o_lcd_rdata    <= 8'h00;
            o_lcd_rdata_oe <= 1'b0;
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
            disp_off       <= 7'd0;
            shift_s        <= 1'b0;
`endif
        end else begin
            en_q           <= i_lcd_en;
            o_err          <= 1'b0;
            o_lcd_rdata_oe <= i_lcd_en & i_lcd_rw;
            o_lcd_rdata    <= (i_lcd_en && i_lcd_rw) ? rd_val : 8'h00;
            if (i_lcd_en) begin
                rs_q   <= i_lcd_rs;
                rw_q   <= i_lcd_rw;
                data_q <= i_lcd_data;
            end
            if (wr_ev && !idle) begin
                o_err <= 1'b1;
            end else if (wr_ev && rs_q) begin
                ac <= ac_step(ac, id_inc, o_two_line);
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                if (shift_s) disp_off <= off_step(disp_off, id_inc, o_two_line);
`endif
            end else if (wr_ev) begin
                casez (data_q)
                    8'b1???????: begin
                        if (ac_illegal(data_q[6:0], o_two_line)) begin
                            ac    <= 7'h00;
                            o_err <= 1'b1;
                        end else begin
                            ac <= data_q[6:0];
                        end
                    end
                    8'b01??????: ;
                    8'b001?????: begin
                        o_dl8      <= data_q[4];
                        o_two_line <= data_q[3];
                    end
                    8'b0001????: begin
                        if (!data_q[3]) ac <= ac_step(ac, data_q[2], o_two_line);
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                        else disp_off <= off_step(disp_off, data_q[2], o_two_line);
`endif
                    end
                    8'b00001???: begin
                        o_disp_on  <= data_q[2];
                        o_cur_on   <= data_q[1];
                        o_blink_on <= data_q[0];
                    end
                    8'b000001??: begin
                        id_inc <= data_q[1];
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                        shift_s <= data_q[0];
`endif
                    end
                    8'b0000001?: begin
                        ac <= 7'h00;
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                        disp_off <= 7'd0;
`endif
                    end
                    8'b00000001: begin
                        ac     <= 7'h00;
                        id_inc <= 1'b1;
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                        disp_off <= 7'd0;
`endif
                    end
                    default: ;
                endcase
            end else if (rd_ev) begin
                if (idle) ac <= ac_step(ac, id_inc, o_two_line);
                else      o_err <= 1'b1;
            end
        end
    end

    // Fill owns both write ports while active; bus writes only happen in IDLE
    always_ff @(posedge i_clk) begin
        if (state == S_FILL) begin
            mem[{1'b0, fill_k}]         <= 8'h20;
            mem[{1'b0, fill_k} + 7'd40] <= 8'h20;
        end else if (wr_data && midx < 7'd80) begin
            mem[midx] <= data_q;
        end
        o_peek_char <= (i_peek_idx < 7'd80) ? mem[i_peek_idx] : 8'h00;
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder: stimulus queues expected probes, a negedge monitor compares them.
module tb_lcd_bus_responder;

    logic       i_clk = 1'b0;
    logic       reset_internal = 1'b1;
    logic [7:0] i_lcd_data = 8'h00;
    logic       i_lcd_rs = 1'b0;
    logic       i_lcd_rw = 1'b0;
    logic       i_lcd_en = 1'b0;
    logic [7:0] o_lcd_rdata;
    logic       o_lcd_rdata_oe;
    logic       o_busy;
    logic [6:0] o_cursor;
    logic       o_disp_on, o_cur_on, o_blink_on, o_dl8, o_two_line;
    logic [6:0] i_peek_idx = 7'd0;
    logic [7:0] o_peek_char;
    logic       o_err;
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
    logic [6:0] o_disp_offset;
`endif

    lcd_bus_responder dut (
        .i_clk(i_clk), .reset_internal(reset_internal),
        .i_lcd_data(i_lcd_data), .i_lcd_rs(i_lcd_rs), .i_lcd_rw(i_lcd_rw), .i_lcd_en(i_lcd_en),
        .o_lcd_rdata(o_lcd_rdata), .o_lcd_rdata_oe(o_lcd_rdata_oe), .o_busy(o_busy),
        .o_cursor(o_cursor), .o_disp_on(o_disp_on), .o_cur_on(o_cur_on), .o_blink_on(o_blink_on),
        .o_dl8(o_dl8), .o_two_line(o_two_line), .i_peek_idx(i_peek_idx),
        .o_peek_char(o_peek_char), .o_err(o_err)
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
        , .o_disp_offset(o_disp_offset)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef enum {P_BUSY, P_RDRAW, P_OE, P_RDATA, P_ERR, P_CURSOR, P_DL8, P_TWO, P_DISP,
                  P_CUR, P_BLINK, P_PEEK, P_ERRCNT, P_BUSYLEN, P_OFFSET} probe_e;
    typedef struct {probe_e p; int exp; string name;} chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt = 0;
    int   busylen = 0;

    always @(posedge i_clk) if (!reset_internal && o_err === 1'b1) err_cnt <= err_cnt + 1;

    task automatic push(input probe_e p, input int exp, input string nm);
        chk_t c;
        c.p = p; c.exp = exp; c.name = nm;
        sb.push_back(c);
    endtask

    // Monitor: compares every queued expectation against the live DUT outputs
    initial begin
        chk_t c;
        int   act;
        forever begin
            @(negedge i_clk);
            while (sb.size() > 0) begin
                c = sb.pop_front();
                case (c.p)
                    P_BUSY:    act = int'(o_busy);
                    P_RDRAW:   act = int'(o_lcd_rdata);
                    P_OE:      act = int'(o_lcd_rdata_oe);
                    P_RDATA:   act = o_lcd_rdata_oe ? int'(o_lcd_rdata) : 'h1FF;
                    P_ERR:     act = int'(o_err);
                    P_CURSOR:  act = int'(o_cursor);
                    P_DL8:     act = int'(o_dl8);
                    P_TWO:     act = int'(o_two_line);
                    P_DISP:    act = int'(o_disp_on);
                    P_CUR:     act = int'(o_cur_on);
                    P_BLINK:   act = int'(o_blink_on);
                    P_PEEK:    act = int'(o_peek_char);
                    P_ERRCNT:  act = err_cnt;
                    P_BUSYLEN: act = busylen;
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
                    P_OFFSET:  act = int'(o_disp_offset);
`endif
                    default:   act = -1;
                endcase
                n_cmp++;
                if (act !== c.exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic wr(input logic rs, input logic [7:0] d, input int gap);
        @(posedge i_clk); #1;
        i_lcd_rs = rs; i_lcd_rw = 1'b0; i_lcd_data = d; i_lcd_en = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_lcd_en = 1'b0;
        repeat (gap) @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic rs, input int exp, input string nm, input int gap);
        @(posedge i_clk); #1;
        i_lcd_rs = rs; i_lcd_rw = 1'b1; i_lcd_en = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 push(P_RDATA, exp, nm);
        @(posedge i_clk); #1;
        i_lcd_en = 1'b0; i_lcd_rw = 1'b0;
        repeat (gap) @(posedge i_clk);
        #1;
    endtask

    task automatic peek(input int idx, input int exp, input string nm);
        @(posedge i_clk); #1 i_peek_idx = 7'(idx);
        @(posedge i_clk); #1 push(P_PEEK, exp, nm);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge i_clk);
        #1;
        push(P_BUSY, 1, "rst_busy");     push(P_OE, 0, "rst_oe");
        push(P_RDRAW, 0, "rst_rdata");   push(P_ERR, 0, "rst_err");
        push(P_CURSOR, 0, "rst_cursor"); push(P_DL8, 1, "rst_dl8");
        push(P_TWO, 0, "rst_two");       push(P_DISP, 0, "rst_disp");
        @(negedge i_clk);
        reset_internal = 1'b0;
        #1;
        busylen = 0;
        while (o_busy === 1'b1 && busylen < 200) begin
            busylen++;
            @(negedge i_clk); #1;
        end
        @(posedge i_clk); #1 push(P_BUSYLEN, 40, "fill_busy_len");
        peek(0, 8'h20, "fill_idx0");   peek(39, 8'h20, "fill_idx39");
        peek(40, 8'h20, "fill_idx40"); peek(79, 8'h20, "fill_idx79");

        // Function set, display control, entry mode
        wr(0, 8'h38, 50); wr(0, 8'h0C, 50); wr(0, 8'h06, 50);
        push(P_DL8, 1, "fs_dl8");   push(P_TWO, 1, "fs_two");
        push(P_DISP, 1, "dc_disp"); push(P_CUR, 0, "dc_cur");
        push(P_BLINK, 0, "dc_blink"); push(P_ERRCNT, 0, "init_no_err");

        // Line-1 end wraps to line 2
        wr(0, 8'hA7, 50); push(P_CURSOR, 8'h27, "set_ac27");
        wr(1, 8'h41, 50); push(P_CURSOR, 8'h40, "wrap_27_40");
        peek(39, 8'h41, "ddram_idx39");
        wr(1, 8'h42, 50); peek(40, 8'h42, "ddram_idx40");
        push(P_CURSOR, 8'h41, "ac_after_42");
        rd(0, 8'h41, "rd_bf_ac", 2);
        rd(1, 8'h20, "rd_data_41", 50);
        push(P_CURSOR, 8'h42, "rd_advances_ac");

        // Decrement across line-2 start back to line-1 end
        wr(0, 8'hC0, 50); wr(0, 8'h04, 50);
        wr(1, 8'h44, 50); push(P_CURSOR, 8'h27, "dec_wrap_40_27");
        peek(40, 8'h44, "dec_write_idx40");
        wr(0, 8'h06, 50);

        // Clear, then accesses while FILL is running
        wr(0, 8'h01, 10);
        wr(1, 8'h55, 2);
        rd(0, 8'h80, "rd_bf_in_fill", 0);
        rd(1, 8'h00, "rd_data_in_fill", 60);
        push(P_ERRCNT, 2, "busy_err_cnt"); push(P_BUSY, 0, "clear_done");
        push(P_CURSOR, 0, "clear_ac");
        peek(0, 8'h20, "dropped_idx0"); peek(39, 8'h20, "cleared_idx39");

        // Address legality in 2-line mode
        wr(0, 8'h38, 50); wr(0, 8'h90, 50);
        push(P_CURSOR, 8'h10, "ac_legal_10"); push(P_ERRCNT, 2, "legal_no_err");
        wr(0, 8'hB0, 50);
        push(P_CURSOR, 0, "ac_illegal_30"); push(P_ERRCNT, 3, "illegal_err");

        // 1-line wrap at 0x4F
        wr(0, 8'h30, 50); push(P_TWO, 0, "one_line");
        wr(0, 8'hCF, 50); push(P_CURSOR, 8'h4F, "ac_4f");
        wr(1, 8'h5A, 50); push(P_CURSOR, 0, "wrap_4f_00");
        peek(79, 8'h5A, "ddram_idx79");
        wr(0, 8'h10, 50); push(P_CURSOR, 8'h4F, "shift_left_wrap");

        // Display shift, then return home
        wr(0, 8'h1C, 50); wr(0, 8'h1C, 50); wr(0, 8'h1C, 50);
        push(P_ERRCNT, 3, "dshift_no_err");
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
        push(P_OFFSET, 3, "offset_3");
`endif
        wr(0, 8'h02, 50);
        push(P_CURSOR, 0, "home_ac"); push(P_BUSY, 0, "home_done");
`ifdef LCD_RESP_DISPLAY_SHIFT_EN
        push(P_OFFSET, 0, "home_offset");
`endif

        repeat (3) @(posedge i_clk);
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
